alu_issue_ctrl: RTL



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_decode.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU front end: ALUType codes,
// instruction class encoding and controller state encoding.
package alu_pkg;

  // ALUType codes understood by the 32-bit ALU
  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLL  = 4'd2;
  localparam logic [3:0] SLT  = 4'd3;
  localparam logic [3:0] XOR  = 4'd4;
  localparam logic [3:0] SRL  = 4'd5;
  localparam logic [3:0] OR   = 4'd6;
  localparam logic [3:0] AND  = 4'd7;
  localparam logic [3:0] NDEF = 4'd8;

  // Decoded instruction class
  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_BR  = 2'd2,
    CLS_RSV = 2'd3
  } cls_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of class/funct3/funct7[5] into the ALUType code and
// the second-operand select (immediate for I-type, rs2 otherwise).
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int ALUopSize = 4
) (
  input  logic [1:0]           i_cls,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7b5,
  output logic [ALUopSize-1:0] o_alu_type,
  output logic                 o_use_imm
);

  // Map the instruction fields onto an ALU operation
  always_comb begin
    o_alu_type = ALUopSize'(NDEF);
    o_use_imm  = 1'b0;
    case (i_cls)
      CLS_R, CLS_I: begin
        o_use_imm = (i_cls == CLS_I);
        case (i_funct3)
          // funct7[5] selects SUB only for register-register ops
          3'b000:  o_alu_type = ALUopSize'(((i_cls == CLS_R) && i_funct7b5) ? SUB : ADD);
          3'b001:  o_alu_type = ALUopSize'(SLL);
          3'b010:  o_alu_type = ALUopSize'(SLT);
          3'b100:  o_alu_type = ALUopSize'(XOR);
          3'b101:  o_alu_type = ALUopSize'(SRL);
          3'b110:  o_alu_type = ALUopSize'(OR);
          3'b111:  o_alu_type = ALUopSize'(AND);
          default: o_alu_type = ALUopSize'(NDEF);
        endcase
      end
      // Branches compare with XOR; equality shows up on the ALU Zero flag
      CLS_BR:  o_alu_type = ALUopSize'(XOR);
      default: o_alu_type = ALUopSize'(NDEF);
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end: accepts one decoded instruction, launches it into
// the external ALU for one cycle, captures the result and branch outcome and
// holds them until the consumer accepts. Not pipelined.
// Optional macro ALU_ILLEGAL_TRAP_EN adds out_err, flagging undefined ops.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_cls,
  input  logic [2:0]           in_funct3,
  input  logic                 in_funct7b5,
  input  logic [DataSize-1:0]  in_rs1,
  input  logic [DataSize-1:0]  in_rs2,
  input  logic [DataSize-1:0]  in_imm,
  output logic [DataSize-1:0]  alu_src1,
  output logic [DataSize-1:0]  alu_src2,
  output logic [ALUopSize-1:0] alu_type,
  output logic                 alu_rst,
  input  logic [DataSize-1:0]  alu_result,
  input  logic                 alu_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataSize-1:0]  out_data,
  output logic                 out_taken
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic                 out_err
`endif
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]           r_state;
  logic [DataSize-1:0]  r_src1;
  logic [DataSize-1:0]  r_src2;
  logic [ALUopSize-1:0] r_type;
  logic [1:0]           r_cls;
  logic [2:0]           r_funct3;
  logic                 r_valid;
  logic [DataSize-1:0]  r_data;
  logic                 r_taken;

  logic [ALUopSize-1:0] w_alu_type;
  logic                 w_use_imm;
  logic                 w_taken;

  alu_op_decode #(
    .ALUopSize (ALUopSize)
  ) u_decode (
    .i_cls      (in_cls),
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .o_alu_type (w_alu_type),
    .o_use_imm  (w_use_imm)
  );

  // Branch outcome from the ALU Zero flag of the XOR compare (BEQ/BNE only)
  always_comb begin
    w_taken = 1'b0;
    if (r_cls == CLS_BR) begin
      if (r_funct3 == 3'b000)      w_taken = alu_zero;
      else if (r_funct3 == 3'b001) w_taken = ~alu_zero;
    end
  end

  assign in_ready  = rst && (r_state == S_IDLE);
  assign alu_rst   = ~rst;
  assign alu_src1  = r_src1;
  assign alu_src2  = r_src2;
  assign alu_type  = r_type;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_taken = r_taken;

  // Issue FSM: IDLE accepts, EXEC lets the ALU settle and captures, DONE holds
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_src1   <= '0;
      r_src2   <= '0;
      r_type   <= ALUopSize'(NDEF);
      r_cls    <= '0;
      r_funct3 <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_taken  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_src1   <= in_rs1;
            r_src2   <= w_use_imm ? in_imm : in_rs2;
            r_type   <= w_alu_type;
            r_cls    <= in_cls;
            r_funct3 <= in_funct3;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_data  <= alu_result;
          r_taken <= w_taken;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic r_err;

  assign out_err = r_err;

  // Remember an undefined decode at accept, flag it with the result
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_illegal <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && in_valid)
        r_illegal <= (w_alu_type == ALUopSize'(NDEF));
      if (r_state == S_EXEC)
        r_err <= r_illegal;
      else if ((r_state == S_DONE) && out_ready)
        r_err <= 1'b0;
    end
  end
`endif

endmodule
